mem_arbiter: RTL and testbench

Shares the single-port instruction/data memory between the fetch stage and the load/store path driven by the control unit's `mem_read`/`mem_write`. Requesters use a req/ack handshake, and the memory side uses a registered req/ack handshake. The block contains a 3-state FSM, a watchdog timeout counter and a halt gate that stops new fetches once `done_ctrl` fires. It sits between the core (PC/fetch logic, load/store datapath) and the memory model.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a shared single-port memory
// Define ARB_RR_EN for round-robin on contention; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int WORD_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              if_ack_nxt, dm_ack_nxt, err_nxt;
  logic [WORD_W-1:0] if_rdata_nxt, dm_rdata_nxt;
  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [WORD_W-1:0] mem_wdata_nxt;
  logic              if_elig, dm_elig, grant_if, grant_dm, timed_out, done;

  assign stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

  // A requester acked this cycle may still show its old req; mask it.
  assign if_elig = if_req & ~halt & ~if_ack;
  assign dm_elig = dm_req & ~dm_ack;

`ifdef ARB_RR_EN
  logic last_dm;

  assign grant_dm = dm_elig & (~if_elig | ~last_dm);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_dm <= 1'b1;
    end else if (state == IDLE && (grant_if || grant_dm)) begin
      last_dm <= grant_dm;
    end
  end
`else
  assign grant_dm = dm_elig;
`endif
  assign grant_if = if_elig & ~grant_dm;

  // The counter holds the number of completed mem_req cycles minus one.
  assign timed_out = ~mem_ack & (cnt == CNT_LAST);
  assign done      = mem_ack | timed_out;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    if_ack_nxt    = 1'b0;
    dm_ack_nxt    = 1'b0;
    err_nxt       = 1'b0;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nxt     = BUSY_DM;
          cnt_nxt       = '0;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = dm_we;
          mem_addr_nxt  = dm_addr;
          mem_wdata_nxt = dm_wdata;
        end else if (grant_if) begin
          state_nxt     = BUSY_IF;
          cnt_nxt       = '0;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
        end
      end
      BUSY_IF: begin
        if (done) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          if_ack_nxt   = 1'b1;
          err_nxt      = timed_out;
          if_rdata_nxt = mem_ack ? mem_rdata : '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BUSY_DM: begin
        if (done) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          dm_ack_nxt   = 1'b1;
          err_nxt      = timed_out;
          dm_rdata_nxt = (mem_ack & ~mem_we) ? mem_rdata : '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      if_ack    <= if_ack_nxt;
      dm_ack    <= dm_ack_nxt;
      err       <= err_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_rdata  <= dm_rdata_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter with a transaction-level model
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W  = 8;
  localparam int WORD_W  = 9;
  localparam int TIMEOUT = 15;

  logic clock = 1'b0, reset = 1'b1, halt = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0, dm_addr = '0;
  logic [WORD_W-1:0] dm_wdata = '0, mem_rdata = '0;
  logic if_ack, dm_ack, err, stall, mem_req, mem_we;
  logic [WORD_W-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic nstep();
    @(negedge clock);
  endtask

  // Transaction-level model: who owns the memory and for how many mem_req cycles.
  int                m_owner;
  int                m_cycles;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [WORD_W-1:0] m_wdata, m_rd;
  bit                e_if_ack, e_dm_ack, e_err, p_if_ack, p_dm_ack, want_if, want_dm, pick_dm;
  logic [WORD_W-1:0] e_if_rdata, e_dm_rdata;
`ifdef ARB_RR_EN
  bit                m_last_dm;
`endif

  always @(posedge clock) begin
    if (reset) begin
      m_owner = 0; m_cycles = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      e_if_ack = 0; e_dm_ack = 0; e_err = 0; e_if_rdata = '0; e_dm_rdata = '0;
`ifdef ARB_RR_EN
      m_last_dm = 1;
`endif
    end else begin
      p_if_ack = e_if_ack; p_dm_ack = e_dm_ack;
      e_if_ack = 0; e_dm_ack = 0; e_err = 0;
      if (m_owner != 0) begin
        m_cycles++;
        if (mem_ack || m_cycles == TIMEOUT) begin
          m_rd  = (mem_ack && !m_we) ? mem_rdata : '0;
          e_err = !mem_ack;
          if (m_owner == 1) begin e_if_ack = 1; e_if_rdata = m_rd; end
          else begin e_dm_ack = 1; e_dm_rdata = m_rd; end
          m_owner = 0;
        end
      end else begin
        want_if = if_req && !halt && !p_if_ack;
        want_dm = dm_req && !p_dm_ack;
`ifdef ARB_RR_EN
        pick_dm = want_dm && !(want_if && m_last_dm);
        if (want_dm || want_if) m_last_dm = pick_dm;
`else
        pick_dm = want_dm;
`endif
        if (pick_dm) begin
          m_owner = 2; m_cycles = 0; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        end else if (want_if) begin
          m_owner = 1; m_cycles = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
        end
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      check("mem_req", mem_req, 32'(m_owner != 0));
      check("if_ack", if_ack, 32'(e_if_ack));
      check("dm_ack", dm_ack, 32'(e_dm_ack));
      check("err", err, 32'(e_err));
      check("stall", stall, 32'((if_req && !e_if_ack) || (dm_req && !e_dm_ack)));
      if (m_owner != 0) begin
        check("mem_we", mem_we, 32'(m_we));
        check("mem_addr", mem_addr, 32'(m_addr));
        check("mem_wdata", mem_wdata, 32'(m_wdata));
      end
      if (e_if_ack) check("if_rdata", if_rdata, 32'(e_if_rdata));
      if (e_dm_ack) check("dm_rdata", dm_rdata, 32'(e_dm_rdata));
    end
  end

  logic [ADDR_W-1:0] order [4];
  logic [ADDR_W-1:0] exp_order [4];
  int ngr, hi, resp_wait, r;
  bit resp_seen;

  initial begin
    repeat (3) nstep();
    check("rst_mem_req", mem_req, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_dm_ack", dm_ack, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    reset = 0;
    chk_en = 1;

    // fetch 0x05, ack one cycle after mem_req
    nstep(); if_req = 1; if_addr = 8'h05;
    nstep(); check("fetch_mem_req", mem_req, 1); check("fetch_mem_addr", mem_addr, 8'h05);
    check("fetch_mem_we", mem_we, 0);
    nstep(); check("fetch_ack_early", if_ack, 0); mem_ack = 1; mem_rdata = 9'h1A3;
    nstep(); check("fetch_ack", if_ack, 1); check("fetch_rdata", if_rdata, 9'h1A3);
    check("fetch_err", err, 0); mem_ack = 0; if_req = 0;
    nstep(); check("fetch_ack_pulse", if_ack, 0);

    // store 0x0FF to 0x10, ack in the third mem_req cycle
    nstep(); dm_req = 1; dm_we = 1; dm_addr = 8'h10; dm_wdata = 9'h0FF; mem_rdata = 9'h155;
    for (int i = 1; i <= 3; i++) begin
      nstep();
      check("store_mem_req", mem_req, 1); check("store_mem_we", mem_we, 1);
      check("store_wdata", mem_wdata, 9'h0FF); check("store_addr", mem_addr, 8'h10);
      check("store_ack_early", dm_ack, 0);
      if (i == 3) mem_ack = 1;
    end
    nstep(); check("store_ack", dm_ack, 1); check("store_rdata", dm_rdata, 0);
    check("store_err", err, 0); mem_ack = 0; dm_req = 0; dm_we = 0;

    // contention with both requests held high
    nstep(); if_req = 1; if_addr = 8'h20; dm_req = 1; dm_we = 0; dm_addr = 8'h30;
    ngr = 0;
    for (int c = 0; c < 60 && ngr < 4; c++) begin
      nstep();
      if (mem_req && !mem_ack) begin
        order[ngr] = mem_addr; ngr++; mem_ack = 1; mem_rdata = 9'(c);
      end else begin
        mem_ack = 0;
      end
    end
    if_req = 0; dm_req = 0;
    nstep(); mem_ack = 0;
    nstep();
`ifdef ARB_RR_EN
    exp_order[0] = 8'h20; exp_order[1] = 8'h30; exp_order[2] = 8'h20; exp_order[3] = 8'h30;
`else
    exp_order[0] = 8'h30; exp_order[1] = 8'h20; exp_order[2] = 8'h30; exp_order[3] = 8'h20;
`endif
    check("contention_grants", 32'(ngr), 4);
    for (int i = 0; i < 4; i++) check($sformatf("contention_grant%0d", i), order[i], exp_order[i]);

    // halt during an in-flight fetch
    nstep(); if_req = 1; if_addr = 8'h44;
    nstep(); check("halt_fetch_req", mem_req, 1); halt = 1;
    nstep(); mem_ack = 1; mem_rdata = 9'h0AB;
    nstep(); check("halt_fetch_ack", if_ack, 1); check("halt_fetch_rdata", if_rdata, 9'h0AB);
    mem_ack = 0; if_addr = 8'h45;
    for (int i = 0; i < 4; i++) begin
      nstep(); check("halt_blocks_fetch", mem_req, 0);
    end
    dm_req = 1; dm_we = 0; dm_addr = 8'h46;
    nstep(); check("halt_dm_req", mem_req, 1); check("halt_dm_addr", mem_addr, 8'h46); mem_ack = 1;
    nstep(); check("halt_dm_ack", dm_ack, 1); check("halt_dm_rdata", dm_rdata, 9'h0AB);
    check("halt_no_if_ack", if_ack, 0); mem_ack = 0; dm_req = 0; if_req = 0; halt = 0;

    // timeout on a load
    nstep(); dm_req = 1; dm_we = 0; dm_addr = 8'h50;
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      nstep();
      if (mem_req) hi++;
      else break;
    end
    check("timeout_len", 32'(hi), TIMEOUT);
    check("timeout_ack", dm_ack, 1); check("timeout_err", err, 1); check("timeout_rdata", dm_rdata, 0);
    dm_req = 0;

    // reset in the second BUSY_DM cycle, then a stray ack and a fresh request
    nstep(); dm_req = 1; dm_we = 1; dm_addr = 8'h60; dm_wdata = 9'h123;
    nstep(); check("rstmid_req", mem_req, 1);
    nstep(); reset = 1; dm_req = 0;
    nstep(); check("rstmid_mem_req", mem_req, 0); check("rstmid_no_ack", dm_ack, 0);
    reset = 0; mem_ack = 1;
    nstep(); check("rstmid_late_ack", mem_req, 0); check("rstmid_late_no_ack", dm_ack, 0);
    mem_ack = 0; dm_req = 1; dm_we = 0; dm_addr = 8'h22;
    nstep(); check("rstmid_regrant", mem_req, 1); check("rstmid_regrant_addr", mem_addr, 8'h22);
    mem_ack = 1; mem_rdata = 9'h1C5;
    nstep(); check("rstmid_ack", dm_ack, 1); check("rstmid_rdata", dm_rdata, 9'h1C5);
    mem_ack = 0; dm_req = 0;

    // randomized traffic against the model
    resp_seen = 0; resp_wait = 0;
    for (int c = 0; c < 4000; c++) begin
      nstep();
      mem_rdata = WORD_W'($urandom);
      mem_ack = 0;
      if (reset) begin
        reset = 0;
      end else if ($urandom_range(0, 499) == 0) begin
        reset = 1; if_req = 0; dm_req = 0; resp_seen = 0;
        continue;
      end
      if ($urandom_range(0, 29) == 0) halt = ~halt;
      if (if_req && if_ack) begin
        if ($urandom_range(0, 1) == 1) if_addr = ADDR_W'($urandom);
        else if_req = 0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = ADDR_W'($urandom);
      end
      if (dm_req && dm_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          dm_addr = ADDR_W'($urandom); dm_we = 1'($urandom); dm_wdata = WORD_W'($urandom);
        end else dm_req = 0;
      end else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_addr = ADDR_W'($urandom); dm_we = 1'($urandom); dm_wdata = WORD_W'($urandom);
      end
      if (mem_req) begin
        if (!resp_seen) begin
          resp_seen = 1;
          r = $urandom_range(0, 9);
          if (r < 6) resp_wait = $urandom_range(0, 3);
          else if (r < 8) resp_wait = $urandom_range(TIMEOUT - 2, TIMEOUT);
          else resp_wait = 99;
        end
        if (resp_wait == 0) mem_ack = 1;
        resp_wait--;
      end else begin
        resp_seen = 0;
        if ($urandom_range(0, 15) == 0) mem_ack = 1;
      end
    end
    reset = 0; if_req = 0; dm_req = 0; mem_ack = 0; halt = 0;
    repeat (TIMEOUT + 4) nstep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
